// File: rtl/event_pulser.sv
// Stretches single-cycle events into ON_CMAX-cycle pulses separated by at least
// OFF_CMAX low cycles, queueing up to PEND_MAX events that arrive meanwhile.
module event_pulser #(
    parameter int ON_CMAX  = 1000,
    parameter int OFF_CMAX = 1000,
    parameter int PEND_MAX = 7,
    parameter int PEND_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              evt,
    output logic              sig,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              ovf
);
    localparam int CMAX  = (ON_CMAX > OFF_CMAX) ? ON_CMAX : OFF_CMAX;
    // A one-cycle phase would give $clog2 of zero, so keep at least one bit.
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CMAX - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CMAX - 1);
    localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [PEND_W-1:0]   pend_nx;
    logic                ovf_nx;
    logic                room;

    assign room = (pend < PEND_TOP);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        pend_nx  = pend;
        ovf_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (evt) state_nx = ON;
            end
            ON: begin
                if (cnt == ON_LAST) begin
                    state_nx = OFF;
                    cnt_nx   = '0;
                end
                if (evt) begin
                    if (room) pend_nx = pend + PEND_W'(1);
                    else      ovf_nx  = 1'b1;
                end
            end
            OFF: begin
                if (cnt == OFF_LAST) begin
                    cnt_nx = '0;
                    // A queued event takes priority; a coincident new one replaces it in the queue.
                    if (pend != '0) begin
                        state_nx = ON;
                        if (!evt) pend_nx = pend - PEND_W'(1);
                    end else if (evt) begin
                        state_nx = ON;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (evt) begin
                    if (room) pend_nx = pend + PEND_W'(1);
                    else      ovf_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                pend_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sig   <= 1'b0;
            busy  <= 1'b0;
            pend  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            sig   <= (state_nx == ON);
            busy  <= (state_nx != IDLE);
            pend  <= pend_nx;
            ovf   <= ovf_nx;
        end
    end
endmodule

// File: tb/tb_event_pulser.sv
// Bench for event_pulser: directed scenarios plus random events, checked against
// a timeline model (pulse start edge + queue count) on two parameterisations.
module tb_event_pulser;
    localparam int A_ON = 4, A_OFF = 3, B_ON = 1, B_OFF = 1, PMAX = 2, PW = 2;

    logic clk = 1'b0, rst_n = 1'b0, evt_a = 1'b0, evt_b = 1'b0;
    logic sig_a, busy_a, ovf_a, sig_b, busy_b, ovf_b;
    logic [PW-1:0] pend_a, pend_b;

    event_pulser #(.ON_CMAX(A_ON), .OFF_CMAX(A_OFF), .PEND_MAX(PMAX), .PEND_W(PW)) dut_a (
        .clk(clk), .rst_n(rst_n), .evt(evt_a), .sig(sig_a), .busy(busy_a), .pend(pend_a), .ovf(ovf_a));
    event_pulser #(.ON_CMAX(B_ON), .OFF_CMAX(B_OFF), .PEND_MAX(PMAX), .PEND_W(PW)) dut_b (
        .clk(clk), .rst_n(rst_n), .evt(evt_b), .sig(sig_b), .busy(busy_b), .pend(pend_b), .ovf(ovf_b));

    always #5 clk = ~clk;

    // Model: a pulse started at edge ps is high for edges [ps, ps+on) and its gap ends at edge ps+on+off.
    typedef struct packed {
        logic started;
        int   ps;
        int   pend;
        logic ovf;
    } mstate_t;

    mstate_t ma, mb;
    int t = 0;
    int tests = 0, fails = 0;

    function automatic mstate_t mstep(mstate_t m, logic e, int tt, int on, int off, int pmax);
        mstate_t r;
        r = m;
        r.ovf = 1'b0;
        if (!m.started) begin
            if (e) begin r.started = 1'b1; r.ps = tt; end
        end else if (tt == m.ps + on + off) begin
            if (m.pend > 0) begin r.ps = tt; r.pend = m.pend - 1 + (e ? 1 : 0); end
            else if (e) r.ps = tt;
            else r.started = 1'b0;
        end else if (e) begin
            if (m.pend < pmax) r.pend = m.pend + 1;
            else r.ovf = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_models();
        chk("sig_a",  32'(sig_a),  32'(ma.started && t < ma.ps + A_ON));
        chk("busy_a", 32'(busy_a), 32'(ma.started));
        chk("pend_a", 32'(pend_a), 32'(ma.pend));
        chk("ovf_a",  32'(ovf_a),  32'(ma.ovf));
        chk("sig_b",  32'(sig_b),  32'(mb.started && t < mb.ps + B_ON));
        chk("busy_b", 32'(busy_b), 32'(mb.started));
        chk("pend_b", 32'(pend_b), 32'(mb.pend));
        chk("ovf_b",  32'(ovf_b),  32'(mb.ovf));
    endtask

    task automatic step(input logic ea, input logic eb);
        evt_a = ea;
        evt_b = eb;
        @(posedge clk);
        t++;
        ma = mstep(ma, ea, t, A_ON, A_OFF, PMAX);
        mb = mstep(mb, eb, t, B_ON, B_OFF, PMAX);
        #1;
        chk_models();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        ma = '0;
        mb = '0;
        chk("rst_sig",  32'(sig_a),  32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_pend", 32'(pend_a), 32'd0);
        chk("rst_ovf",  32'(ovf_a),  32'd0);
        chk("rst_b",    32'({sig_b, busy_b, pend_b, ovf_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rises, highs;
        logic prev;
        evt_a = 1'b0;
        evt_b = 1'b0;
        #2;
        async_reset();

        // 1: single event
        step(1'b1, 1'b0);                 // e0
        chk("t1_sig_e0", 32'(sig_a), 32'd1);
        idle(3);                          // e3
        chk("t1_sig_e3", 32'(sig_a), 32'd1);
        step(1'b0, 1'b0);                 // e4
        chk("t1_sig_e4", 32'(sig_a), 32'd0);
        idle(2);                          // e6
        chk("t1_busy_e6", 32'(busy_a), 32'd1);
        step(1'b0, 1'b0);                 // e7
        chk("t1_busy_e7", 32'(busy_a), 32'd0);
        idle(3);

        // 2: second event queued during the first pulse
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);   // e0..e2
        chk("t2_pend_e2", 32'(pend_a), 32'd1);
        idle(4);                          // e6
        chk("t2_sig_e6", 32'(sig_a), 32'd0);
        step(1'b0, 1'b0);                 // e7
        chk("t2_sig_e7", 32'(sig_a), 32'd1);
        chk("t2_pend_e7", 32'(pend_a), 32'd0);
        idle(3);                          // e10
        chk("t2_sig_e10", 32'(sig_a), 32'd1);
        step(1'b0, 1'b0);                 // e11
        chk("t2_sig_e11", 32'(sig_a), 32'd0);
        idle(2);                          // e13
        chk("t2_busy_e13", 32'(busy_a), 32'd1);
        step(1'b0, 1'b0);                 // e14
        chk("t2_busy_e14", 32'(busy_a), 32'd0);
        idle(3);

        // 3: event held for four cycles overflows the two-deep queue
        step(1'b1, 1'b0);                 // e0
        step(1'b1, 1'b0);                 // e1
        chk("t3_pend_e1", 32'(pend_a), 32'd1);
        step(1'b1, 1'b0);                 // e2
        chk("t3_pend_e2", 32'(pend_a), 32'd2);
        chk("t3_ovf_e2", 32'(ovf_a), 32'd0);
        step(1'b1, 1'b0);                 // e3
        chk("t3_ovf_e3", 32'(ovf_a), 32'd1);
        rises = 1;
        prev = sig_a;
        for (int i = 4; i < 30; i++) begin
            step(1'b0, 1'b0);
            if (i == 4) chk("t3_ovf_e4", 32'(ovf_a), 32'd0);
            if (i == 7 || i == 14) chk("t3_rise", 32'({prev, sig_a}), 32'b01);
            if (sig_a && !prev) rises++;
            prev = sig_a;
        end
        chk("t3_pulses", 32'(rises), 32'd3);

        // 4: event exactly at the end of the gap restarts with no idle cycle
        step(1'b1, 1'b0);                 // e0
        idle(6);                          // e6
        step(1'b1, 1'b0);                 // e7
        chk("t4_sig_e7", 32'(sig_a), 32'd1);
        chk("t4_pend_e7", 32'(pend_a), 32'd0);
        chk("t4_busy_e7", 32'(busy_a), 32'd1);
        idle(6);                          // e13
        chk("t4_busy_e13", 32'(busy_a), 32'd1);
        step(1'b0, 1'b0);                 // e14
        chk("t4_busy_e14", 32'(busy_a), 32'd0);
        idle(2);

        // 5: asynchronous reset mid-pulse with a full queue
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        chk("t5_pend_full", 32'(pend_a), 32'd2);
        async_reset();
        highs = 0;
        step(1'b1, 1'b0);
        if (sig_a) highs++;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            if (sig_a) highs++;
        end
        chk("t5_pulse_len", 32'(highs), 32'd4);

        // 6: one-cycle pulse and gap, event held for six cycles
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1);
            chk("t6_sig_toggle", 32'(sig_b), 32'((k % 2) == 0));
        end
        chk("t6_pend_sat", 32'(pend_b), 32'd2);
        idle(12);

        // Random events on both instances, with one reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset();
            step(($urandom_range(3) == 0) || (i % 97 < 5), $urandom_range(2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
